// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging INPUTS valid/ready requesters into one registered output beat buffer.
// Define HS_RR_ARB_FRAME_LOCK_EN to hold the grant on one requester until its last beat.
module handshake_rr_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int INPUTS     = 3,
  localparam int SRC_W     = $clog2(INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*DATA_WIDTH-1:0] din_data,
  input  logic [INPUTS-1:0]            din_last,
  input  logic [INPUTS-1:0]            din_vld,
  output logic [INPUTS-1:0]            din_rd,
  output logic [DATA_WIDTH-1:0]        dout_data,
  output logic                         dout_last,
  output logic [SRC_W-1:0]             dout_src,
  output logic                         dout_vld,
  input  logic                         dout_rd
);

  // Handshake: a beat moves on any rising edge where its valid and ready are both high;
  // valid never waits for ready, and a held beat stays stable until it is taken.

  logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
  logic                  dout_last_q, dout_last_d;
  logic [SRC_W-1:0]      dout_src_q, dout_src_d;
  logic                  dout_vld_q, dout_vld_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;

  logic [INPUTS-1:0]     elig;
  logic [SRC_W-1:0]      cand;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  load_en;
  logic                  take;

`ifdef HS_RR_ARB_FRAME_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} lock_state_e;
  lock_state_e      state_q, state_d;
  logic [SRC_W-1:0] lock_idx_q, lock_idx_d;

  // While a frame is open only its owner may be granted.
  always_comb begin
    elig = {INPUTS{1'b1}};
    if (state_q == S_LOCKED) elig = INPUTS'(1) << lock_idx_q;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (take) begin
      if (state_q == S_IDLE && !din_last[grant_idx]) begin
        state_d    = S_LOCKED;
        lock_idx_d = grant_idx;
      end else if (state_q == S_LOCKED && din_last[grant_idx]) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign elig = {INPUTS{1'b1}};
`endif

  // Scan starts one past the last winner and wraps modulo INPUTS.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= INPUTS; k++) begin
      cand = SRC_W'((int'(ptr_q) + k) % INPUTS);
      if (!grant_any && din_vld[cand] && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign load_en = !dout_vld_q || dout_rd;
  assign take    = grant_any && load_en && !rst;
  assign din_rd  = take ? (INPUTS'(1) << grant_idx) : '0;

  always_comb begin
    dout_data_d = dout_data_q;
    dout_last_d = dout_last_q;
    dout_src_d  = dout_src_q;
    dout_vld_d  = dout_vld_q;
    ptr_d       = ptr_q;
    if (take) begin
      dout_data_d = din_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      dout_last_d = din_last[grant_idx];
      dout_src_d  = grant_idx;
      dout_vld_d  = 1'b1;
      ptr_d       = grant_idx;
    end else if (dout_rd) begin
      dout_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_data_q <= '0;
      dout_last_q <= 1'b0;
      dout_src_q  <= '0;
      dout_vld_q  <= 1'b0;
      ptr_q       <= SRC_W'(INPUTS - 1);
    end else begin
      dout_data_q <= dout_data_d;
      dout_last_q <= dout_last_d;
      dout_src_q  <= dout_src_d;
      dout_vld_q  <= dout_vld_d;
      ptr_q       <= ptr_d;
    end
  end

  assign dout_data = dout_data_q;
  assign dout_last = dout_last_q;
  assign dout_src  = dout_src_q;
  assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Randomized bench for handshake_rr_arbiter: a queue-based reference model predicts grants and
// output beats; a separate monitor pops expected beats whenever the sink takes one.
module tb_handshake_rr_arbiter;
  localparam int DW = 2;
  localparam int N  = 3;
  localparam int SW = $clog2(N);
  localparam int BW = SW + 1 + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] din_data;
  logic [N-1:0]    din_last;
  logic [N-1:0]    din_vld;
  logic [N-1:0]    din_rd;
  logic [DW-1:0]   dout_data;
  logic            dout_last;
  logic [SW-1:0]   dout_src;
  logic            dout_vld;
  logic            dout_rd;

  always #5 clk = ~clk;

  handshake_rr_arbiter #(.DATA_WIDTH(DW), .INPUTS(N)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_last(din_last), .din_vld(din_vld), .din_rd(din_rd),
    .dout_data(dout_data), .dout_last(dout_last), .dout_src(dout_src),
    .dout_vld(dout_vld), .dout_rd(dout_rd)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: last winner, open-frame owner (-1 none), buffer occupancy.
  int m_ptr;
  int m_lock;
  bit m_full;
  int rst_cycles = 0;

  function automatic int pick(input logic [N-1:0] v, input int p, input int lk);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i] && (lk < 0 || lk == i)) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rd;
    if (rst) begin
      check("rd_in_rst", 32'(din_rd), 32'(0));
      if (rst_cycles > 0) begin
        check("rst_vld", 32'(dout_vld), 32'(0));
        check("rst_src", 32'(dout_src), 32'(0));
        check("rst_data", 32'(dout_data), 32'(0));
        check("rst_last", 32'(dout_last), 32'(0));
      end
      rst_cycles++;
      m_ptr  = N - 1;
      m_lock = -1;
      m_full = 1'b0;
      exp_q.delete();
    end else begin
      rst_cycles = 0;
      check("dout_vld", 32'(dout_vld), 32'(m_full));
      g = (m_full && !dout_rd) ? -1 : pick(din_vld, m_ptr, m_lock);
      exp_rd = (g >= 0) ? (N'(1) << g) : '0;
      check("din_rd", 32'(din_rd), 32'(exp_rd));
      if (g >= 0) begin
        exp_q.push_back({SW'(g), din_last[g], din_data[g*DW +: DW]});
        m_ptr  = g;
        m_full = 1'b1;
`ifdef HS_RR_ARB_FRAME_LOCK_EN
        if (m_lock < 0 && !din_last[g]) m_lock = g;
        else if (m_lock >= 0 && din_last[g]) m_lock = -1;
`endif
      end else if (dout_rd) begin
        m_full = 1'b0;
      end
    end
  end

  logic [BW-1:0] held;
  logic [BW-1:0] got;
  bit held_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      got = {dout_src, dout_last, dout_data};
      if (held_v) check("hold_stable", 32'(got), 32'(held));
      if (dout_vld && dout_rd) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got %0h expected none", got);
        end else begin
          check("beat", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      held_v = dout_vld && !dout_rd;
      held   = got;
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N*DW-1:0] d, input logic rd);
    din_vld  = v;
    din_last = l;
    din_data = d;
    dout_rd  = rd;
    @(posedge clk);
    #1;
  endtask

  logic [N*DW-1:0] d123;

  initial begin
    for (int i = 0; i < N; i++) d123[i*DW +: DW] = DW'(i + 1);
    // Reset with every requester asking.
    rst = 1'b1;
    repeat (3) step('1, '1, d123, 1'b1);
    rst = 1'b0;
    // Fairness: all asking, sink always ready.
    repeat (6) step('1, '1, d123, 1'b1);
    // Backpressure then release.
    repeat (5) step('1, '1, d123, 1'b0);
    repeat (2) step('1, '1, d123, 1'b1);
    // Skip idle requesters and wrap.
    step(3'b001, '1, d123, 1'b1);
    step(3'b100, '1, d123, 1'b1);
    step(3'b001, '1, d123, 1'b1);
    step(3'b100, '1, d123, 1'b1);
    // Three-beat frame from req0 while req1 keeps asking.
    step(3'b011, 3'b010, N*DW'($urandom), 1'b1);
    step(3'b011, 3'b010, N*DW'($urandom), 1'b1);
    step(3'b011, 3'b011, N*DW'($urandom), 1'b1);
    step(3'b010, 3'b111, N*DW'($urandom), 1'b1);
    step(3'b000, 3'b000, d123, 1'b1);
    // Reset in the middle of a frame.
    step(3'b111, 3'b000, d123, 1'b1);
    rst = 1'b1;
    repeat (2) step(3'b111, 3'b000, d123, 1'b1);
    rst = 1'b0;
    repeat (3) step('1, '1, d123, 1'b1);
    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(N'($urandom), N'($urandom), N*DW'($urandom), $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;
    repeat (4) step('0, '0, '0, 1'b1);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
